conv_seq_ctrl: RTL and testbench
================================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 The block SHALL take parameter IMG_W, default 8, meaning input feature-map width and height in pixels.
REQ-002 The block SHALL take parameter KSZ, default 3, meaning square kernel size.
REQ-003 The block SHALL take parameter LEAD, default 20, meaning pipeline fill cycles before the first valid conv result.
REQ-004 The block SHALL derive OUT_W = IMG_W-KSZ+1 (6), CNT_MAX = LEAD+OUT_W*IMG_W-1 (67) and CNT_W = $clog2(CNT_MAX+1) (7).
REQ-005 The block SHALL have port clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 The block SHALL have port start, input, 1 bit, a frame request pulse.
REQ-008 The block SHALL have port hold, input, 1 bit, a downstream stall (see Configuration).
REQ-009 The block SHALL have port busy, output, 1 bit, high while a frame is sequencing.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle frame-complete pulse.
REQ-011 The block SHALL have port cnt, output, CNT_W bits, the frame cycle counter driving the storage stage.
REQ-012 The block SHALL have port cap_en, output, 1 bit, the result capture strobe.
REQ-013 The block SHALL have port out_row, output, 3 bits, the output row index of the current capture.
REQ-014 The block SHALL have port out_col, output, 3 bits, the output column index of the current capture.
REQ-015 The block SHALL have port out_addr, output, 6 bits, the flat result address (out_row*OUT_W+out_col).
REQ-016 The block SHALL have port out_last, output, 1 bit, marking the final capture of the frame.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to RUN with cnt=0 on the next cycle; start SHALL be ignored in RUN and DONE.
REQ-019 In RUN, cnt SHALL increment by 1 per cycle unless stalled; when cnt=CNT_MAX and not stalled, cnt SHALL return to 0 and the FSM SHALL move to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE; cnt SHALL hold 0 in IDLE and DONE.
REQ-021 busy SHALL equal (state==RUN), decoded combinationally from the state register.
REQ-022 Latency: with start sampled at cycle T and no stall, cnt=0 SHALL occur at T+1, cnt=67 at T+68 and done at T+69.
REQ-023 cap_en SHALL be a combinational decode: state==RUN, not stalled, cnt>=LEAD, and ((cnt-LEAD) mod IMG_W) < OUT_W; with defaults this gives windows 20-25, 28-33, 36-41, 44-49, 52-57 and 60-65.
REQ-024 out_col and out_row SHALL be registers that reset to 0 at each start.
REQ-025 On each cap_en, out_col SHALL increment; at OUT_W-1 it SHALL wrap to 0 and out_row SHALL increment.
REQ-026 out_addr SHALL be combinational from out_row and out_col and SHALL be valid whenever cap_en=1.
REQ-027 out_last SHALL equal cap_en AND out_addr==OUT_W*OUT_W-1 (35).
REQ-028 The block SHALL produce exactly OUT_W*OUT_W (36) cap_en pulses per frame.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force state=IDLE, cnt=0, out_row=0 and out_col=0, giving busy=0, done=0, cap_en=0 and out_last=0.
REQ-030 A reset mid-frame SHALL abort the frame with no done pulse; the next start SHALL begin a full frame from cnt=0.

Configuration
REQ-031 When macro CONV_SEQ_HOLD_EN is defined, hold=1 in RUN SHALL stall: cnt, out_row and out_col freeze and cap_en=0; the FSM SHALL not leave RUN while stalled.
REQ-032 When CONV_SEQ_HOLD_EN is undefined, the hold port SHALL remain present but be ignored, and the frame length SHALL always be CNT_MAX+1 cycles.

Verification
REQ-033 Reset then start pulse at cycle 0 -> busy rises at cycle 1, cnt runs 0..67, done is high at cycle 69 only, busy is low from cycle 69.
REQ-034 Single frame -> exactly 36 cap_en pulses, at cnt 20-25, 28-33, ..., 60-65; out_addr runs 0..35 in order; out_last is high only at cnt=65.
REQ-035 Start held high for 100 cycles -> back-to-back frames with one IDLE cycle between done and the next cnt=0; no start is accepted during RUN.
REQ-036 rst_n pulsed low at cnt=40 -> all outputs are 0 immediately; a new start yields a clean 36-capture frame with out_addr starting at 0.
REQ-037 With CONV_SEQ_HOLD_EN, hold=1 for 5 cycles at cnt=30 -> cnt stays 30 and cap_en=0 for those cycles; done arrives 5 cycles late; capture count is still 36.
REQ-038 Without CONV_SEQ_HOLD_EN, the same hold stimulus -> timing is identical to REQ-033.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: frame sequencer for a sliding-window convolution engine.
// After a start request it runs a cycle counter over the whole frame, then
// raises a capture strobe with (row, col, address) for each valid output
// pixel once the pipeline has filled.
// Optional feature: define CONV_SEQ_HOLD_EN to make the hold input stall the
// sequencer. Without it, hold is accepted but has no effect.

module conv_seq_ctrl #(
  parameter  int IMG_W   = 8,
  parameter  int KSZ     = 3,
  parameter  int LEAD    = 20,
  localparam int OUT_W   = IMG_W - KSZ + 1,
  localparam int CNT_MAX = LEAD + OUT_W * IMG_W - 1,
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic             cap_en,
  output logic [2:0]       out_row,
  output logic [2:0]       out_col,
  output logic [5:0]       out_addr,
  output logic             out_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             stall;
  logic             in_window;
  logic [CNT_W-1:0] rel;

`ifdef CONV_SEQ_HOLD_EN
  assign stall = hold;
`else
  // hold is kept on the port for pin compatibility but deliberately unused.
  logic hold_unused;
  assign hold_unused = hold;
  assign stall       = 1'b0;
`endif

  // Frame-position decode: past the fill latency, each input row of IMG_W
  // cycles yields OUT_W valid results followed by KSZ-1 dead cycles.
  assign rel       = cnt - CNT_W'(LEAD);
  assign in_window = (cnt >= CNT_W'(LEAD)) &&
                     ((rel % CNT_W'(IMG_W)) < CNT_W'(OUT_W));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!stall && (cnt == CNT_W'(CNT_MAX))) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture strobe only while actively sequencing and not stalled.
  assign cap_en = busy && !stall && in_window;

  // Frame cycle counter: advances in RUN unless stalled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == RUN) begin
      if (!stall) begin
        if (cnt == CNT_W'(CNT_MAX)) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Output pixel coordinates: cleared when a frame is accepted, stepped in
  // raster order on every capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if ((state == IDLE) && start) begin
      out_row <= '0;
      out_col <= '0;
    end else if (cap_en) begin
      if (out_col == 3'(OUT_W - 1)) begin
        out_col <= '0;
        out_row <= out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end
  end

  // Flat result address and end-of-frame marker.
  assign out_addr = 6'(out_row) * 6'(OUT_W) + 6'(out_col);
  assign out_last = cap_en && (out_addr == 6'(OUT_W * OUT_W - 1));

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl. A frame-position model predicts every output
// each cycle from the frame rules (position within the frame, arithmetic
// row/column of each capture); directed scenarios add literal expectations.
// Honors CONV_SEQ_HOLD_EN the same way the design does.

module tb_conv_seq_ctrl;

  localparam int IMG_W   = 8;
  localparam int KSZ     = 3;
  localparam int LEAD    = 20;
  localparam int OUT_W   = IMG_W - KSZ + 1;
  localparam int CNT_MAX = LEAD + OUT_W * IMG_W - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef CONV_SEQ_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             hold  = 1'b0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic             cap_en;
  logic [2:0]       out_row;
  logic [2:0]       out_col;
  logic [5:0]       out_addr;
  logic             out_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl #(.IMG_W(IMG_W), .KSZ(KSZ), .LEAD(LEAD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt),
    .cap_en   (cap_en),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_addr (out_addr),
    .out_last (out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: whether a frame is running, its position, and a done cycle flag.
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int m_pos  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_pos  = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (!(HOLD_EN && hold)) begin
      if (m_pos == CNT_MAX) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    int rel;
    int e_row;
    int e_col;
    bit e_cap;
    rel   = m_pos - LEAD;
    e_row = rel / IMG_W;
    e_col = rel % IMG_W;
    e_cap = m_run && !(HOLD_EN && hold) && (m_pos >= LEAD) && (e_col < OUT_W);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("cnt", cnt, m_run ? m_pos : 0);
    check("cap_en", cap_en, e_cap);
    check("out_last", out_last, e_cap && (e_row * OUT_W + e_col == OUT_W * OUT_W - 1));
    if (e_cap) begin
      check("out_addr", out_addr, e_row * OUT_W + e_col);
      check("out_row", out_row, e_row);
      check("out_col", out_col, e_col);
    end
  end

  // Per-cycle recording of one scenario; index = cycles after the start cycle.
  logic rec_busy [0:127];
  logic rec_done [0:127];
  logic rec_cap  [0:127];
  logic rec_last [0:127];
  int   rec_cnt  [0:127];
  int   rec_addr [0:127];

  // Entered just after a rising edge (cycle 0). start is high in cycles
  // 0..start_until-1, hold in cycles hold_from..hold_to.
  task automatic run(input int ncyc, input int start_until, input int hold_from, input int hold_to);
    start = 1'b1;
    hold  = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      start = (cyc < start_until);
      hold  = (cyc >= hold_from) && (cyc <= hold_to);
      @(negedge clk);
      rec_busy[cyc] = busy;
      rec_done[cyc] = done;
      rec_cap[cyc]  = cap_en;
      rec_last[cyc] = out_last;
      rec_cnt[cyc]  = int'(cnt);
      rec_addr[cyc] = int'(out_addr);
    end
    @(posedge clk); #1;
    start = 1'b0;
    hold  = 1'b0;
  endtask

  function automatic int count_caps(input int ncyc);
    int n = 0;
    for (int i = 1; i <= ncyc; i++) if (rec_cap[i]) n++;
    return n;
  endfunction

  function automatic int count_done(input int ncyc);
    int n = 0;
    for (int i = 1; i <= ncyc; i++) if (rec_done[i]) n++;
    return n;
  endfunction

  function automatic int first_done(input int ncyc);
    for (int i = 1; i <= ncyc; i++) if (rec_done[i]) return i;
    return -1;
  endfunction

  // Captures must present addresses 0,1,2,... in order; returns the number out of place.
  function automatic int addr_order_errs(input int ncyc);
    int k = 0;
    int bad = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (rec_cap[i]) begin
        if (rec_addr[i] != k) bad++;
        k++;
      end
    end
    return bad;
  endfunction

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_cap_en", cap_en, 0);
    check("rst_out_last", out_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, no hold.
    run(75, 1, 0, -1);
    check("A_busy_c1", rec_busy[1], 1);
    check("A_cnt_c1", rec_cnt[1], 0);
    check("A_cnt_c68", rec_cnt[68], 67);
    check("A_done_cycle", first_done(75), 69);
    check("A_done_count", count_done(75), 1);
    check("A_busy_c69", rec_busy[69], 0);
    check("A_caps", count_caps(75), 36);
    check("A_cap_c20", rec_cap[20], 0);
    check("A_cap_c21", rec_cap[21], 1);
    check("A_cap_c27", rec_cap[27], 0);
    check("A_cap_c29", rec_cap[29], 1);
    check("A_addr_c21", rec_addr[21], 0);
    check("A_addr_order", addr_order_errs(75), 0);
    check("A_last_c66", rec_last[66], 1);
    check("A_last_c65", rec_last[65], 0);

    // hold high for 5 cycles starting where cnt=30.
    run(80, 1, 31, 35);
    check("B_cnt_c33", rec_cnt[33], HOLD_EN ? 30 : 32);
    check("B_cap_c32", rec_cap[32], HOLD_EN ? 0 : 1);
    check("B_done_cycle", first_done(80), HOLD_EN ? 74 : 69);
    check("B_done_count", count_done(80), 1);
    check("B_caps", count_caps(80), 36);
    check("B_addr_order", addr_order_errs(80), 0);

    // start held high: back-to-back frames separated by one IDLE cycle.
    run(100, 101, 0, -1);
    check("C_done_c69", rec_done[69], 1);
    check("C_busy_c70", rec_busy[70], 0);
    check("C_done_c70", rec_done[70], 0);
    check("C_busy_c71", rec_busy[71], 1);
    check("C_cnt_c71", rec_cnt[71], 0);
    check("C_cnt_c100", rec_cnt[100], 29);
    check("C_done_count", count_done(100), 1);
    repeat (45) @(posedge clk);
    #1;

    // Reset mid-frame at cnt=40, then a clean frame.
    run(40, 1, 0, -1);
    check("D_cnt_pre", cnt, 40);
    rst_n = 1'b0;
    #1;
    check("D_rst_busy", busy, 0);
    check("D_rst_cnt", cnt, 0);
    check("D_rst_cap_en", cap_en, 0);
    check("D_rst_out_addr", out_addr, 0);
    check("D_rst_out_last", out_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run(75, 1, 0, -1);
    check("D_caps", count_caps(75), 36);
    check("D_addr_c21", rec_addr[21], 0);
    check("D_addr_order", addr_order_errs(75), 0);
    check("D_done_cycle", first_done(75), 69);
    check("D_done_count", count_done(75), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
